// File: rtl/alu8_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding, ALU opcode constants, flag bit positions
// and a helper that packs the ALU flags into the response flag vector.
package alu8_arb_pkg;

   localparam int unsigned ALU_DATA_W = 8;
   localparam int unsigned ALU_OP_W   = 4;
   localparam int unsigned FLAG_W     = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic [ALU_OP_W-1:0] OP_INV = 4'd0;
   localparam logic [ALU_OP_W-1:0] OP_AND = 4'd1;
   localparam logic [ALU_OP_W-1:0] OP_OR  = 4'd2;
   localparam logic [ALU_OP_W-1:0] OP_SRL = 4'd3;
   localparam logic [ALU_OP_W-1:0] OP_SLL = 4'd4;
   localparam logic [ALU_OP_W-1:0] OP_SRA = 4'd5;
   localparam logic [ALU_OP_W-1:0] OP_SLA = 4'd6;
   localparam logic [ALU_OP_W-1:0] OP_ADD = 4'd7;
   localparam logic [ALU_OP_W-1:0] OP_ROR = 4'd8;
   localparam logic [ALU_OP_W-1:0] OP_ROL = 4'd9;

   localparam int unsigned FLAG_OF   = 2;
   localparam int unsigned FLAG_ZERO = 1;
   localparam int unsigned FLAG_SLT  = 0;

   // Place each ALU flag at its documented bit position.
   function automatic logic [FLAG_W-1:0] pack_flags(input logic of_f,
                                                    input logic zero_f,
                                                    input logic slt_f);
      logic [FLAG_W-1:0] f;
      f            = '0;
      f[FLAG_OF]   = of_f;
      f[FLAG_ZERO] = zero_f;
      f[FLAG_SLT]  = slt_f;
      return f;
   endfunction

endpackage

// File: rtl/alu8_arbiter_rr_arb2.sv
// Combinational two-way grant for the ALU arbiter.
// Build option: ALU8_ARB_FIXED_PRIO_EN selects fixed priority (requester 0
// wins ties); otherwise ties go to the requester that did not win last.
// Ports:
//   req_valid  in  2  pending requests
//   last_grant in  1  requester accepted most recently
//   grant_c    out 2  one-hot grant (00 when nothing is pending)
module rr_arb2 (
   input  logic [1:0] req_valid,
   input  logic       last_grant,
   output logic [1:0] grant_c
);

`ifdef ALU8_ARB_FIXED_PRIO_EN
   // Pointer is kept by the parent for debug only.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   always_comb begin
      grant_c = 2'b00;
      case (req_valid)
         2'b01:   grant_c = 2'b01;
         2'b10:   grant_c = 2'b10;
         2'b11: begin
`ifdef ALU8_ARB_FIXED_PRIO_EN
            grant_c = 2'b01;
`else
            grant_c = last_grant ? 2'b01 : 2'b10;
`endif
         end
         default: grant_c = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu8_arbiter.sv
// Shares one external combinational 8-bit ALU between two requesters.
// One operation is in flight at a time: IDLE (arbitrate/accept) -> EXEC
// (ALU settles on registered operands) -> RESP (hold response until taken).
// Build option: ALU8_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin,
// honoured inside rr_arb2).
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             per-requester handshake (ready only in IDLE)
//   req_op0/1, req_a0/1, req_b0/1   request payloads
//   alu_op, alu_a, alu_b            registered ALU inputs
//   alu_result, alu_of/zero/slt     ALU outputs
//   resp_valid/resp_ready           response handshake
//   resp_id, resp_result, resp_flags  captured response ({of, zero, slt})
//   busy                            high whenever not IDLE
module alu8_arbiter
   import alu8_arb_pkg::*;
#(
   parameter int unsigned DATA_W = ALU_DATA_W,
   parameter int unsigned OP_W   = ALU_OP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [OP_W-1:0]   req_op0,
   input  logic [OP_W-1:0]   req_op1,
   input  logic [DATA_W-1:0] req_a0,
   input  logic [DATA_W-1:0] req_a1,
   input  logic [DATA_W-1:0] req_b0,
   input  logic [DATA_W-1:0] req_b1,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_of,
   input  logic              alu_zero,
   input  logic              alu_slt,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_id,
   output logic [DATA_W-1:0] resp_result,
   output logic [FLAG_W-1:0] resp_flags,
   output logic              busy
);

   arb_state_t state;
   logic       last_grant;
   logic [1:0] grant_c;
   logic       winner_c;

   rr_arb2 u_rr_arb2 (
      .req_valid  (req_valid),
      .last_grant (last_grant),
      .grant_c    (grant_c)
   );

   assign winner_c = grant_c[1];

   // Ready is the live grant, only offered in IDLE and never while in reset.
   assign req_ready  = ((state == IDLE) && !rst) ? grant_c : 2'b00;
   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);

   // Single-process FSM plus datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         alu_op      <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         resp_id     <= 1'b0;
         resp_result <= '0;
         resp_flags  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_c != 2'b00) begin
                  alu_op     <= winner_c ? req_op1 : req_op0;
                  alu_a      <= winner_c ? req_a1  : req_a0;
                  alu_b      <= winner_c ? req_b1  : req_b0;
                  resp_id    <= winner_c;
                  last_grant <= winner_c;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               // ALU has had a full cycle to settle on the registered operands.
               resp_result <= alu_result;
               resp_flags  <= pack_flags(alu_of, alu_zero, alu_slt);
               state       <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu8_arbiter.sv
// Self-checking bench for alu8_arbiter: directed cases plus randomized
// operations, checked against a transaction-level model (arbitration pointer
// and a behavioural ALU that also serves as the DUT's ALU).
module tb_alu8_arbiter;
   import alu8_arb_pkg::*;

   logic       clk;
   logic       rst;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [3:0] req_op0, req_op1;
   logic [7:0] req_a0, req_a1, req_b0, req_b1;
   logic [3:0] alu_op;
   logic [7:0] alu_a, alu_b;
   logic [7:0] alu_result;
   logic       alu_of, alu_zero, alu_slt;
   logic       resp_valid, resp_ready, resp_id;
   logic [7:0] resp_result;
   logic [2:0] resp_flags;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;
   logic last_w;

   alu8_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op0(req_op0), .req_op1(req_op1),
      .req_a0(req_a0), .req_a1(req_a1),
      .req_b0(req_b0), .req_b1(req_b1),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_of(alu_of), .alu_zero(alu_zero), .alu_slt(alu_slt),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_result(resp_result), .resp_flags(resp_flags), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: returns {of, zero, slt, result[7:0]}.
   function automatic logic [10:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
      logic [7:0] r;
      logic       of;
      int         n;
      r  = 8'h00;
      of = 1'b0;
      n  = int'(b[2:0]);
      case (op)
         OP_INV: r = ~a;
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_SRL: r = a >> n;
         OP_SLL: r = a << n;
         OP_SRA: r = 8'($signed(a) >>> n);
         OP_SLA: r = a << n;
         OP_ADD: begin
            r  = 8'(int'(a) + int'(b));
            of = (a[7] == b[7]) && (r[7] != a[7]);
         end
         OP_ROR: begin
            r = a;
            for (int i = 0; i < n; i++) r = {r[0], r[7:1]};
         end
         OP_ROL: begin
            r = a;
            for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
         end
         default: r = 8'h00;
      endcase
      return {of, (r == 8'h00), ($signed(a) < $signed(b)), r};
   endfunction

   logic [10:0] alu_out;
   assign alu_out    = alu_ref(alu_op, alu_a, alu_b);
   assign alu_result = alu_out[7:0];
   assign alu_of     = alu_out[10];
   assign alu_zero   = alu_out[9];
   assign alu_slt    = alu_out[8];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // Arbitration rule: a lone request wins; a tie goes away from the last winner.
   function automatic logic pick_winner(input logic [1:0] vld);
      if (vld == 2'b01) return 1'b0;
      if (vld == 2'b10) return 1'b1;
`ifdef ALU8_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return ~last_w;
`endif
   endfunction

   task automatic check_reset_values();
      check_eq("rst_ready", 32'(req_ready), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
      check_eq("rst_alu", {20'h0, alu_op, alu_a}, 32'h0);
      check_eq("rst_alu_b", 32'(alu_b), 32'h0);
      check_eq("rst_resp", {20'h0, resp_id, resp_flags, resp_result}, 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 2'b00;
      resp_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_reset_values();
      rst = 1'b0;
      last_w = 1'b1;
   endtask

   // One complete transaction, with `stall` cycles of response backpressure.
   task automatic run_op(input logic [1:0] vld,
                         input logic [3:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic [3:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                         input int stall);
      logic        w;
      logic [10:0] exp;
      logic [3:0]  eop;
      logic [7:0]  ea, eb;
      req_valid = vld;
      req_op0 = op0; req_a0 = a0; req_b0 = b0;
      req_op1 = op1; req_a1 = a1; req_b1 = b1;
      resp_ready = 1'b0;
      #1;
      w = pick_winner(vld);
      check_eq("grant", 32'(req_ready), w ? 32'h2 : 32'h1);
      check_eq("busy_idle", 32'(busy), 32'h0);
      @(posedge clk); #1;
      last_w = w;
      eop = w ? op1 : op0;
      ea  = w ? a1 : a0;
      eb  = w ? b1 : b0;
      exp = alu_ref(eop, ea, eb);
      // The loser keeps waiting; it must not be offered ready while busy.
      req_valid = vld & (w ? 2'b01 : 2'b10);
      #1;
      check_eq("exec_ready", 32'(req_ready), 32'h0);
      check_eq("exec_busy", 32'(busy), 32'h1);
      check_eq("exec_resp_valid", 32'(resp_valid), 32'h0);
      check_eq("alu_regs", {12'h0, alu_op, alu_a, alu_b}, {12'h0, eop, ea, eb});
      @(posedge clk); #1;
      check_eq("resp_valid", 32'(resp_valid), 32'h1);
      check_eq("resp_id", 32'(resp_id), 32'(w));
      check_eq("resp_result", 32'(resp_result), 32'(exp[7:0]));
      check_eq("resp_flags", 32'(resp_flags), 32'(exp[10:8]));
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         check_eq("stall_valid", 32'(resp_valid), 32'h1);
         check_eq("stall_resp", {20'h0, resp_id, resp_flags, resp_result},
                  {20'h0, w, exp[10:8], exp[7:0]});
         check_eq("stall_ready", 32'(req_ready), 32'h0);
         check_eq("stall_busy", 32'(busy), 32'h1);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid = 2'b00;
      check_eq("done_resp_valid", 32'(resp_valid), 32'h0);
      check_eq("done_busy", 32'(busy), 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 2'b00;
      req_op0 = '0; req_op1 = '0;
      req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
      resp_ready = 1'b0;
      last_w = 1'b1;
      do_reset();

      // First request after reset: AND from requester 0.
      run_op(2'b01, OP_AND, 8'hF0, 8'h3C, OP_OR, 8'h00, 8'h00, 0);
      check_eq("and_result_directed", 32'(alu_ref(OP_AND, 8'hF0, 8'h3C) & 11'h0FF), 32'h30);

      // Simultaneous requests, four in a row, from reset.
      do_reset();
      for (int k = 0; k < 4; k++)
         run_op(2'b11, OP_ADD, 8'(k), 8'h01, OP_OR, 8'(k), 8'h80, 0);

      // Long backpressure with both requesters waiting.
      run_op(2'b11, OP_SRA, 8'h90, 8'h02, OP_ROL, 8'h81, 8'h01, 5);

      // Signed overflow on ADD from requester 1.
      run_op(2'b10, OP_INV, 8'h00, 8'h00, OP_ADD, 8'h7F, 8'h01, 1);

      // Unassigned opcode: result zero, no hang.
      run_op(2'b01, 4'd12, 8'h55, 8'hAA, OP_AND, 8'h00, 8'h00, 0);

      // Reset while in EXEC discards the transaction.
      req_valid = 2'b10; req_op1 = OP_OR; req_a1 = 8'h0F; req_b1 = 8'hF0;
      @(posedge clk); #1;
      req_valid = 2'b00;
      check_eq("pre_rst_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_values();
      rst = 1'b0;
      last_w = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check_eq("no_resp_after_rst", 32'(resp_valid), 32'h0);
      end
      run_op(2'b11, OP_SLL, 8'h03, 8'h04, OP_SRL, 8'hC0, 8'h03, 0);

      // Randomized traffic with idle gaps and random backpressure.
      for (int t = 0; t < 40; t++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            check_eq("idle_ready", 32'(req_ready), 32'h0);
            check_eq("idle_busy", 32'(busy), 32'h0);
         end
         run_op(2'($urandom_range(1, 3)),
                4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu8_arbiter.md
Name: alu8_arbiter

Overview:
- Shares one combinational 8-bit ALU (4-bit op, 8-bit a/b, flags addOF/zero/slt) between two requesters.
- Accepts one operation at a time over a valid/ready request channel, using round-robin arbitration.
- Drives the ALU from registers, captures result and flags, and returns them on a valid/ready response channel tagged with the requester id.
- Sits between two client controllers and a single ALU8bit instance, which is instantiated outside this block.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- OP_W, 4, opcode width; must match the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i = requester i has an operation pending.
- req_ready  out  2  bit i = operation of requester i accepted this cycle.
- req_op0 / req_op1  in  OP_W  opcode of requester 0 / 1.
- req_a0 / req_a1  in  DATA_W  operand a of requester 0 / 1.
- req_b0 / req_b1  in  DATA_W  operand b of requester 0 / 1.
- alu_op  out  OP_W  registered opcode to the ALU.
- alu_a / alu_b  out  DATA_W  registered operands to the ALU.
- alu_result  in  DATA_W  ALU result.
- alu_of, alu_zero, alu_slt  in  1  ALU flags.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  1  requester that issued the operation.
- resp_result  out  DATA_W  captured result.
- resp_flags  out  3  {of, zero, slt}, captured.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset:
  - State = IDLE; last_grant = 1, so requester 0 wins first.
  - alu_op, alu_a, alu_b, resp_result, resp_flags, resp_id = 0.
  - resp_valid = 0, req_ready = 00, busy = 0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE. No other states; unreachable encodings go to IDLE.
- IDLE arbitration:
  - Grant is combinational from req_valid and last_grant.
  - Exactly one valid -> that requester wins.
  - Both valid -> the requester other than last_grant wins.
  - Neither valid -> no grant.
  - req_ready[i] = grant_i while in IDLE; always 00 in EXEC and RESP.
- Accept (valid & ready, IDLE):
  - Register the winner's op/a/b into alu_op/alu_a/alu_b.
  - Record resp_id and set last_grant = winner.
  - Go to EXEC.
- EXEC (exactly one cycle; ALU settle):
  - At the end of the cycle, capture alu_result into resp_result and {alu_of, alu_zero, alu_slt} into resp_flags.
  - Go to RESP.
- RESP:
  - resp_valid = 1; resp_* held stable until resp_ready.
  - On resp_ready, go to IDLE. No new accept in the same cycle.
- Latency and throughput:
  - Accept in cycle N -> resp_valid first high in cycle N+2.
  - Peak throughput is one operation per 3 cycles.
- Opcodes: not checked. Ops 10..15 are issued normally; the ALU returns 0 and the flags are passed through unmodified.
- alu_* registers hold their last values outside EXEC. They change only on accept.
- Response backpressure: req_ready stays 00 for the whole stall. A requester holding valid keeps its data stable; dropping valid before acceptance is legal.
- Requester switching: the round-robin pointer updates only on accept, never on a request that was withdrawn.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is produced, and all values return to reset values.

Optional Feature:
- Macro: ALU8_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both are valid, and last_grant is ignored (still updated for debug).
- Undefined: round-robin as specified above.
- The port list is identical in both builds.

Decomposition:
- Package alu8_arb_pkg holds:
  - FSM state encodings IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - Opcode constants OP_INV=0, OP_AND=1, OP_OR=2, OP_SRL=3, OP_SLL=4, OP_SRA=5, OP_SLA=6, OP_ADD=7, OP_ROR=8, OP_ROL=9.
  - Flag bit indices FLAG_OF=2, FLAG_ZERO=1, FLAG_SLT=0.
- One sub-module, rr_arb2: combinational 2-way grant from req_valid and last_grant. The fixed-priority macro is honoured inside it.

Test Plan:
- After reset, only req_valid=01 with op=OP_AND, a=8'hF0, b=8'h3C -> req_ready=01 for 1 cycle; two cycles later resp_valid=1, resp_id=0, resp_result=8'h30.
- Both valid at the same time -> grants alternate 0,1,0,1 over four operations; with ALU8_ARB_FIXED_PRIO_EN defined, all four go to requester 0.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_* stable, req_ready=00, busy=1; response consumed on the cycle resp_ready=1, IDLE the next cycle.
- Requester 1, op=OP_ADD, a=8'h7F, b=8'h01 with a model ALU -> resp_result=8'h80, resp_flags[FLAG_OF]=1.
- Assert rst during EXEC -> no resp_valid ever; all outputs at reset values the next cycle; the next request goes to requester 0.
- Requester 0, op=4'd12 -> resp_result=8'h00, resp_flags equal to the model ALU flags, no hang.
